// File: rtl/param_pattern_gen_pkg.sv
// Shared types and width helpers for the parameterised pattern generator.
// Imported by the interface, the next-value sub-module and the top.
package param_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ModeConst = 2'd0,
    ModeIncr  = 2'd1,
    ModeLfsr  = 2'd2,
    ModeWalk1 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Channel index width; a single channel still needs one bit of port.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Beat counter width, sized to hold the full burst count without overflow.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total + 1) : 1;
  endfunction

endpackage

// File: rtl/param_pattern_gen_if.sv
// Control and beat-stream signals of the pattern generator.
// master = generator side, slave = controller/consumer side.
interface param_pattern_gen_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) ();
  import param_pattern_gen_pkg::*;

  localparam int ChW = int'(ch_width(NUM_CH));

  logic             start;
  logic             abort;
  mode_e            mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [ChW-1:0]   out_ch;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  abort,
    input  mode,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_ch,
    output out_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output mode,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_ch,
    input  out_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/pgen_next_value.sv
// Combinational next-pattern step for the four pattern modes.
module pgen_next_value
  import param_pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] value,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_value
);

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] walk_next;

  // Galois form: shift right, fold the taps in when a one falls out.
  assign lfsr_next = (value >> 1) ^ (value[0] ? TAPS : '0);
  // Shift-or form stays legal for WIDTH == 1, where the rotate is identity.
  assign walk_next = (value << 1) | (value >> (WIDTH - 1));

  always_comb begin
    next_value = value;
    case (mode)
      ModeConst: next_value = value;
      ModeIncr:  next_value = value + WIDTH'(1);
      ModeLfsr:  next_value = lfsr_next;
      ModeWalk1: next_value = walk_next;
      default:   next_value = value;
    endcase
  end

endmodule

// File: rtl/param_pattern_gen.sv
// Round-robin multi-channel burst pattern generator (CONST/INCR/LFSR/WALK1)
// with a valid/ready beat stream, abort, and a one-cycle done pulse.
module param_pattern_gen
  import param_pattern_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NUM_CH    = 2,
  parameter int               BURST_LEN = 3,
  parameter bit [WIDTH-1:0]   SEED      = 8'hAB,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter string            NAME      = "pgen"
) (
  input logic                 clk,
  input logic                 rst,
  param_pattern_gen_if.master bus
);

  localparam int unsigned Total = BURST_LEN * NUM_CH;
  localparam int          ChW   = int'(ch_width(NUM_CH));
  localparam int          CntW  = int'(cnt_width(Total));

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("%s: WIDTH must be in 1..64, got %0d", NAME, WIDTH);
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("%s: NUM_CH must be in 1..16, got %0d", NAME, NUM_CH);
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("%s: BURST_LEN must be >= 1, got %0d", NAME, BURST_LEN);
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] load_value;
  logic             handshake;
  logic             last_beat;
  logic             last_ch;

  pgen_next_value #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next_value (
    .value      (value_q),
    .mode       (mode_q),
    .next_value (step_value)
  );

  // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
  always_comb begin
    load_value = WIDTH'(SEED);
    if (bus.mode == ModeWalk1) begin
      load_value = WIDTH'(1);
    end else if (bus.mode == ModeLfsr && SEED == '0) begin
      load_value = WIDTH'(1);
    end
  end

  assign handshake = (state_q == StRun) && bus.out_ready;
  assign last_beat = (cnt_q == CntW'(Total - 1));
  assign last_ch   = (ch_q == ChW'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    value_d = value_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        // abort outranks start; start is only looked at here.
        if (bus.start && !bus.abort) begin
          state_d = StRun;
          mode_d  = bus.mode;
          value_d = load_value;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
          ch_d    = '0;
          cnt_d   = '0;
        end else if (handshake) begin
          if (last_beat) begin
            state_d = StDone;
            ch_d    = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (last_ch) begin
              ch_d    = '0;
              value_d = step_value;
            end else begin
              ch_d = ch_q + ChW'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        ch_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= ModeConst;
      value_q <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign bus.out_valid = (state_q == StRun);
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.out_data  = value_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_last  = (state_q == StRun) && last_beat;

endmodule

// File: tb/tb_param_pattern_gen.sv
// Directed bench for param_pattern_gen at default parameters.
module tb_param_pattern_gen;
  import param_pattern_gen_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [7:0] got_data[$];
  logic       got_ch[$];
  logic       got_last[$];
  bit         timed_out;

  param_pattern_gen_if #(.WIDTH(8), .NUM_CH(2)) bus ();

  param_pattern_gen #(
    .WIDTH     (8),
    .NUM_CH    (2),
    .BURST_LEN (3),
    .SEED      (8'hAB),
    .TAPS      (8'hB8),
    .NAME      ("pgen")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input mode_e m);
    bus.start = 1'b1;
    bus.mode  = m;
    cycle();
    bus.start = 1'b0;
  endtask

  // Records handshaken beats until the last one; leaves time in the DONE cycle.
  task automatic collect();
    timed_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_ch.push_back(bus.out_ch);
        got_last.push_back(bus.out_last);
        if (bus.out_last) begin
          cycle();
          timed_out = 1'b0;
          break;
        end
      end
      cycle();
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_ch.delete();
    got_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000",
               {bus.out_valid, bus.out_last, bus.busy, bus.done});
      n_fail++;
    end
    n_tests++;
    if ({bus.out_data, bus.out_ch} !== 9'h000) begin
      $display("FAIL reset_data_ch: got %h/%h want 00/0", bus.out_data, bus.out_ch);
      n_fail++;
    end
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_idle_valid: got %b want 0", bus.out_valid);
      n_fail++;
    end
  endtask

  task automatic test_mode(input mode_e m, input string tag,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
    logic [7:0] exp_v[3];
    exp_v[0] = e0;
    exp_v[1] = e1;
    exp_v[2] = e2;
    clear_log();
    bus.out_ready = 1'b1;
    start_burst(m);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      $display("FAIL %s_first_valid: valid/busy %b%b want 11", tag, bus.out_valid, bus.busy);
      n_fail++;
    end
    collect();
    n_tests++;
    if (timed_out || got_data.size() != 6) begin
      $display("FAIL %s_beats: got %0d beats (timeout %0b) want 6", tag, got_data.size(),
               timed_out);
      n_fail++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (got_data[i] !== exp_v[i/2] || got_ch[i] !== 1'(i % 2) ||
            got_last[i] !== (i == 5)) begin
          $display("FAIL %s_beat%0d: data %h ch %b last %b want %h %b %b", tag, i,
                   got_data[i], got_ch[i], got_last[i], exp_v[i/2], 1'(i % 2), (i == 5));
          n_fail++;
        end
      end
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL %s_done: done/busy/valid %b%b%b want 100", tag, bus.done, bus.busy,
               bus.out_valid);
      n_fail++;
    end
    cycle();
    n_tests++;
    if (bus.done !== 1'b0) begin
      $display("FAIL %s_done_pulse: got %b want 0", tag, bus.done);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    clear_log();
    bus.out_ready = 1'b1;
    start_burst(ModeIncr);
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAC || bus.out_ch !== 1'b0 ||
          bus.out_last !== 1'b0) begin
        $display("FAIL stall_hold%0d: v %b data %h ch %b last %b want 1 ac 0 0", k,
                 bus.out_valid, bus.out_data, bus.out_ch, bus.out_last);
        n_fail++;
      end
    end
    bus.out_ready = 1'b1;
    collect();
    n_tests++;
    if (timed_out || got_data.size() != 4 || got_data[0] !== 8'hAC ||
        got_data[3] !== 8'hAD) begin
      $display("FAIL stall_rest: got %0d beats want 4 (ac..ad), timeout %0b",
               got_data.size(), timed_out);
      n_fail++;
    end
    n_tests++;
    if (bus.done !== 1'b1) begin
      $display("FAIL stall_done: got %b want 1", bus.done);
      n_fail++;
    end
    cycle();
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b1;
    start_burst(ModeIncr);
    cycle();
    cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    n_tests++;
    if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
      $display("FAIL abort_idle: valid/busy/done %b want 000",
               {bus.out_valid, bus.busy, bus.done});
      n_fail++;
    end
    cycle();
    n_tests++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL abort_no_done: done %b valid %b want 0 0", bus.done, bus.out_valid);
      n_fail++;
    end
    start_burst(ModeIncr);
    n_tests++;
    if (bus.out_data !== 8'hAB || bus.out_ch !== 1'b0 || bus.out_last !== 1'b0) begin
      $display("FAIL abort_restart: data %h ch %b last %b want ab 0 0", bus.out_data,
               bus.out_ch, bus.out_last);
      n_fail++;
    end
    clear_log();
    collect();
    n_tests++;
    if (timed_out || got_data.size() != 6) begin
      $display("FAIL abort_restart_len: got %0d want 6", got_data.size());
      n_fail++;
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    start_burst(ModeLfsr);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000 ||
        bus.out_data !== 8'h00 || bus.out_ch !== 1'b0) begin
      $display("FAIL reset_mid: v/l/b/d %b data %h ch %b want 0000 00 0",
               {bus.out_valid, bus.out_last, bus.busy, bus.done}, bus.out_data, bus.out_ch);
      n_fail++;
    end
    cycle();
    rst = 1'b0;
    cycle();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL reset_mid_after: done %b busy %b want 0 0", bus.done, bus.busy);
      n_fail++;
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    bus.out_ready = 1'b1;
    start_burst(ModeIncr);
    got_data.push_back(bus.out_data);
    got_ch.push_back(bus.out_ch);
    got_last.push_back(bus.out_last);
    bus.start = 1'b1;
    bus.mode  = ModeLfsr;
    cycle();
    bus.start = 1'b0;
    collect();
    n_tests++;
    if (timed_out || got_data.size() != 6 || got_data[2] !== 8'hAC ||
        got_data[5] !== 8'hAD) begin
      $display("FAIL start_in_run: got %0d beats, timeout %0b, want 6 incr beats",
               got_data.size(), timed_out);
      n_fail++;
    end
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL start_in_done: busy %b valid %b want 0 0", bus.busy, bus.out_valid);
      n_fail++;
    end
    cycle();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL start_not_queued: busy %b want 0", bus.busy);
      n_fail++;
    end
  endtask

  task automatic test_start_abort();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.mode  = ModeIncr;
    cycle();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL start_abort_idle: busy %b valid %b want 0 0", bus.busy, bus.out_valid);
      n_fail++;
    end
    cycle();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL start_abort_stay: busy %b done %b want 0 0", bus.busy, bus.done);
      n_fail++;
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.mode      = ModeConst;
    bus.out_ready = 1'b0;
    test_reset();
    test_mode(ModeIncr, "incr", 8'hAB, 8'hAC, 8'hAD);
    test_mode(ModeLfsr, "lfsr", 8'hAB, 8'hED, 8'hCE);
    test_mode(ModeWalk1, "walk1", 8'h01, 8'h02, 8'h04);
    test_mode(ModeConst, "const", 8'hAB, 8'hAB, 8'hAB);
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_start_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
